// File: rtl/omok_board_ctrl.sv
// Omok board game-state controller: cursor navigation, stone placement,
// turn alternation and a bounded circular undo history.
module omok_board_ctrl #(
    parameter int N          = 10,
    parameter int HIST_DEPTH = 16,
    parameter int POS_W      = $clog2(N*N),
    parameter int CNT_W      = $clog2(N*N+1),
    parameter int HC_W       = $clog2(HIST_DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             up,
    input  logic             down,
    input  logic             put,
    input  logic             undo,
    output logic [N*N-1:0]   board_state,
    output logic [N*N-1:0]   turn_map,
    output logic [POS_W-1:0] cursor_pos,
    output logic             next_white,
    output logic [CNT_W-1:0] move_count,
    output logic [HC_W-1:0]  hist_count,
    output logic             board_full,
    output logic             put_err,
    output logic             undo_err
);

    localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    localparam logic [POS_W-1:0] N_P      = POS_W'(N);
    localparam logic [POS_W-1:0] EDGE_P   = POS_W'(N-1);
    localparam logic [POS_W-1:0] CUR_RST  = POS_W'((N/2-1)*N + (N/2-1));
    localparam logic [CNT_W-1:0] CELLS_C  = CNT_W'(N*N);
    localparam logic [HC_W-1:0]  HC_MAX   = HC_W'(HIST_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(HIST_DEPTH-1);

    typedef enum logic [2:0] {
        ACT_NONE, ACT_UNDO, ACT_PUT, ACT_RIGHT, ACT_LEFT, ACT_UP, ACT_DOWN
    } act_t;

    logic [5:0]       btn;
    logic [5:0]       btn_prev;
    logic [5:0]       ev;
    act_t             act;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] ptr_prev;
    logic [POS_W-1:0] pop_pos;
    logic [POS_W-1:0] hist [HIST_DEPTH];

    assign btn = {undo, put, right, left, up, down};
    assign ev  = btn & ~btn_prev;

    // One action per cycle; lower-priority events in the same cycle are dropped.
    always_comb begin
        act = ACT_NONE;
        if      (ev[5]) act = ACT_UNDO;
        else if (ev[4]) act = ACT_PUT;
        else if (ev[3]) act = ACT_RIGHT;
        else if (ev[2]) act = ACT_LEFT;
        else if (ev[1]) act = ACT_UP;
        else if (ev[0]) act = ACT_DOWN;
    end

    assign row      = cursor_pos / N_P;
    assign col      = cursor_pos % N_P;
    assign ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    assign ptr_prev = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
    assign pop_pos  = hist[ptr_prev];

    assign board_full = (move_count == CELLS_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev    <= '1;
            board_state <= '0;
            turn_map    <= '0;
            cursor_pos  <= CUR_RST;
            next_white  <= 1'b0;
            move_count  <= '0;
            hist_count  <= '0;
            wr_ptr      <= '0;
            put_err     <= 1'b0;
            undo_err    <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
        end else begin
            btn_prev <= btn;
            put_err  <= 1'b0;
            undo_err <= 1'b0;
            case (act)
                ACT_UNDO: begin
                    if (hist_count != '0) begin
                        board_state[pop_pos] <= 1'b0;
                        turn_map[pop_pos]    <= 1'b0;
                        next_white           <= ~next_white;
                        move_count           <= move_count - CNT_W'(1);
                        hist_count           <= hist_count - HC_W'(1);
                        cursor_pos           <= pop_pos;
                        wr_ptr               <= ptr_prev;
                    end else begin
                        undo_err <= 1'b1;
                    end
                end
                ACT_PUT: begin
                    if (board_state[cursor_pos]) begin
                        put_err <= 1'b1;
                    end else begin
                        board_state[cursor_pos] <= 1'b1;
                        turn_map[cursor_pos]    <= next_white;
                        next_white              <= ~next_white;
                        move_count              <= move_count + CNT_W'(1);
                        hist[wr_ptr]            <= cursor_pos;
                        wr_ptr                  <= ptr_next;
                        // Full history overwrites the oldest entry; count saturates.
                        if (hist_count != HC_MAX) hist_count <= hist_count + HC_W'(1);
                    end
                end
                ACT_RIGHT: if (col != EDGE_P) cursor_pos <= cursor_pos + POS_W'(1);
                ACT_LEFT:  if (col != '0)     cursor_pos <= cursor_pos - POS_W'(1);
                ACT_UP:    if (row != '0)     cursor_pos <= cursor_pos - N_P;
                ACT_DOWN:  if (row != EDGE_P) cursor_pos <= cursor_pos + N_P;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_omok_board_ctrl.sv
// Directed bench for omok_board_ctrl (N=10, HIST_DEPTH=16): a vector table
// for single actions plus hand sequences for history overflow, fill and reset.
module tb_omok_board_ctrl;

    localparam int N  = 10;
    localparam int HD = 16;

    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_UNDO  = 6'b100000;
    localparam logic [5:0] B_PUT   = 6'b010000;
    localparam logic [5:0] B_RIGHT = 6'b001000;
    localparam logic [5:0] B_LEFT  = 6'b000100;
    localparam logic [5:0] B_UP    = 6'b000010;
    localparam logic [5:0] B_DOWN  = 6'b000001;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic           put = 1'b0, undo = 1'b0;
    logic [N*N-1:0] board_state;
    logic [N*N-1:0] turn_map;
    logic [6:0]     cursor_pos;
    logic           next_white;
    logic [6:0]     move_count;
    logic [4:0]     hist_count;
    logic           board_full;
    logic           put_err;
    logic           undo_err;

    int checks   = 0;
    int failures = 0;
    int cur      = 44;

    omok_board_ctrl #(.N(N), .HIST_DEPTH(HD)) dut (
        .clk(clk), .rst(rst),
        .left(left), .right(right), .up(up), .down(down),
        .put(put), .undo(undo),
        .board_state(board_state), .turn_map(turn_map),
        .cursor_pos(cursor_pos), .next_white(next_white),
        .move_count(move_count), .hist_count(hist_count),
        .board_full(board_full), .put_err(put_err), .undo_err(undo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] btn;
        int         cur;
        int         mc;
        int         hc;
        logic       nw;
        logic       occ;
        logic       wh;
        logic       pe;
        logic       ue;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [N*N-1:0] act, input logic [N*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [5:0] b);
        {undo, put, right, left, up, down} = b;
    endtask

    // Press for one cycle; returns at the negedge after the action edge.
    task automatic go(input logic [5:0] b);
        @(negedge clk);
        set_btn(b);
        @(negedge clk);
        set_btn(B_NONE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur = 44;
    endtask

    task automatic move_to(input int target);
        while (cur != target) begin
            if (cur % N < target % N)      begin go(B_RIGHT); cur = cur + 1; end
            else if (cur % N > target % N) begin go(B_LEFT);  cur = cur - 1; end
            else if (cur / N < target / N) begin go(B_DOWN);  cur = cur + N; end
            else                           begin go(B_UP);    cur = cur - N; end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk_vec({tag, "_board"}, board_state, '0);
        chk_vec({tag, "_turn"}, turn_map, '0);
        chk({tag, "_cursor"}, int'(cursor_pos), 44);
        chk({tag, "_next_white"}, int'(next_white), 0);
        chk({tag, "_move_count"}, int'(move_count), 0);
        chk({tag, "_hist_count"}, int'(hist_count), 0);
        chk({tag, "_board_full"}, int'(board_full), 0);
        chk({tag, "_put_err"}, int'(put_err), 0);
        chk({tag, "_undo_err"}, int'(undo_err), 0);
    endtask

    initial begin
        logic [N*N-1:0] exp_tm;
        int hist_cells[18];

        tbl[0]  = '{B_PUT,          44, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{B_PUT,          44, 1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{B_UNDO,         44, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{B_UNDO,         44, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{B_RIGHT,        45, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{B_RIGHT,        46, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{B_RIGHT,        47, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{B_RIGHT,        48, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{B_RIGHT,        49, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{B_RIGHT,        49, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{B_UP,           39, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{B_UP,           29, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{B_UP,           19, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{B_UP,            9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{B_UP,            9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{B_LEFT,          8, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{B_DOWN,         18, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{B_PUT,          18, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{B_RIGHT,        19, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{B_PUT,          19, 2, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{B_UNDO | B_PUT, 19, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{B_LEFT | B_RIGHT, 19, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{B_LEFT | B_DOWN, 18, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{B_UP | B_DOWN,    8, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset values while reset is held and after release.
        #12;
        chk_reset_state("in_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("post_reset");

        // Single-action vectors.
        for (int i = 0; i < 24; i++) begin
            go(tbl[i].btn);
            chk($sformatf("v%0d_cursor", i), int'(cursor_pos), tbl[i].cur);
            chk($sformatf("v%0d_move_count", i), int'(move_count), tbl[i].mc);
            chk($sformatf("v%0d_hist_count", i), int'(hist_count), tbl[i].hc);
            chk($sformatf("v%0d_next_white", i), int'(next_white), int'(tbl[i].nw));
            chk($sformatf("v%0d_occupied", i), int'(board_state[tbl[i].cur]), int'(tbl[i].occ));
            chk($sformatf("v%0d_colour", i), int'(turn_map[tbl[i].cur]), int'(tbl[i].wh));
            chk($sformatf("v%0d_put_err", i), int'(put_err), int'(tbl[i].pe));
            chk($sformatf("v%0d_undo_err", i), int'(undo_err), int'(tbl[i].ue));
            @(negedge clk);
            chk($sformatf("v%0d_put_err_drop", i), int'(put_err), 0);
            chk($sformatf("v%0d_undo_err_drop", i), int'(undo_err), 0);
        end

        // History overflow: 18 stones, 17 undos.
        do_reset();
        for (int i = 0; i < 10; i++) hist_cells[i] = i;
        for (int i = 0; i < 8; i++) hist_cells[10 + i] = 19 - i;
        for (int i = 0; i < 18; i++) begin
            move_to(hist_cells[i]);
            go(B_PUT);
        end
        chk("hist_fill_move_count", int'(move_count), 18);
        chk("hist_fill_hist_count", int'(hist_count), 16);
        for (int i = 0; i < 17; i++) begin
            go(B_UNDO);
            chk($sformatf("hist_undo%0d_err", i), int'(undo_err), (i == 16) ? 1 : 0);
        end
        chk("hist_move_count", int'(move_count), 2);
        chk("hist_hist_count", int'(hist_count), 0);
        chk("hist_cursor", int'(cursor_pos), 2);
        chk("hist_next_white", int'(next_white), 0);
        chk_vec("hist_board", board_state, 100'h3);
        chk_vec("hist_turn", turn_map, 100'h2);

        // Fill the whole board row-major; colours alternate from black.
        do_reset();
        for (int i = 0; i < N*N; i++) begin
            move_to(i);
            go(B_PUT);
        end
        exp_tm = '0;
        for (int i = 0; i < N*N; i++) exp_tm[i] = (i % 2 == 1);
        chk("full_move_count", int'(move_count), 100);
        chk("full_board_full", int'(board_full), 1);
        chk("full_hist_count", int'(hist_count), 16);
        chk("full_cursor", int'(cursor_pos), 99);
        chk_vec("full_board", board_state, '1);
        chk_vec("full_turn", turn_map, exp_tm);
        go(B_PUT);
        chk("full_put_err", int'(put_err), 1);
        chk("full_put_move_count", int'(move_count), 100);
        chk("full_put_next_white", int'(next_white), 0);

        // Reset mid-fill with put held high across reset release.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            move_to(i);
            go(B_PUT);
        end
        chk("midfill_move_count", int'(move_count), 5);
        @(negedge clk);
        put = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_vec("async_rst_board", board_state, '0);
        chk("async_rst_move_count", int'(move_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("held_put");
        put = 1'b0;
        cur = 44;
        go(B_PUT);
        chk("after_held_move_count", int'(move_count), 1);
        chk("after_held_occupied", int'(board_state[44]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
